// File: rtl/fc_ctrl_pkg.sv
// FC sequencer shared types and width helpers.
// Optional stall counter is enabled by FC_STALL_CNT_EN.
package fc_ctrl_pkg;

  typedef enum logic [2:0] {
    LOAD,
    PREP,
    MAC,
    DRAIN,
    OUT
  } fc_state_t;

  function automatic int vec_aw(input int n);
    return $clog2(n);
  endfunction

  function automatic int mat_aw(
    input int m,
    input int n,
    input int p
  );
    return $clog2(m * n / p);
  endfunction

endpackage

// File: rtl/fc_ctrl_cnt.sv
// Wrap counter: counts 0..MAX, then wraps.
// Synchronous clear wins over enable.
module fc_ctrl_cnt
  import fc_ctrl_pkg::*;
#(
  parameter int MAX = 7,
  parameter int W   = vec_aw(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_nxt;

  assign tc = (cnt == W'(MAX));

  // next count: clear, wrap at MAX, or step
  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = tc ? '0 : cnt + W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: load x, then M rows of N MACs.
// Define FC_STALL_CNT_EN to add the stall_cnt output.
module fc_seq_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 8,
  parameter int T = 8,
  parameter int P = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [vec_aw(N)-1:0]    addr_x,
  output logic                    wr_en_x,
  output logic [mat_aw(M,N,P)-1:0] addr_w,
  output logic                    wr_en_w,
  output logic                    clear_acc,
  output logic                    en_acc,
  output logic [P-1:0]            f_sel
`ifdef FC_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int XW = vec_aw(N);
  localparam int WW = mat_aw(M, N, P);
  localparam int RW = vec_aw(M);

  if (P != 1) begin : g_p_chk
    $error("fc_seq_ctrl: only P=1 supported");
  end

  if (T < 1) begin : g_t_chk
    $error("fc_seq_ctrl: T must be positive");
  end

  fc_state_t state;
  fc_state_t state_n;

  logic [XW-1:0] load_cnt;
  logic          load_tc;
  logic [XW-1:0] k_cnt;
  logic          k_tc;
  logic [RW-1:0] row_cnt;
  logic          row_tc;

  logic accept;
  logic out_hs;
  logic clr_all;

  logic [XW-1:0] kx;
  logic          ir_d;
  logic          ov_d;
  logic          ca_d;
  logic [XW-1:0] ax_d;
  logic [WW-1:0] aw_d;

  assign accept  = input_ready & input_valid;
  assign out_hs  = (state == OUT) & output_ready;
  assign clr_all = out_hs & row_tc;

  assign wr_en_x = accept;
  assign wr_en_w = 1'b0;
  assign f_sel   = '0;

  fc_ctrl_cnt #(.MAX(N - 1), .W(XW)) u_load_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr_all),
    .en    (accept),
    .cnt   (load_cnt),
    .tc    (load_tc)
  );

  fc_ctrl_cnt #(.MAX(N - 1), .W(XW)) u_k_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr_all),
    .en    (state == MAC),
    .cnt   (k_cnt),
    .tc    (k_tc)
  );

  fc_ctrl_cnt #(.MAX(M - 1), .W(RW)) u_row_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr_all),
    .en    (out_hs),
    .cnt   (row_cnt),
    .tc    (row_tc)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= LOAD;
    else
      state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:    if (accept && load_tc) state_n = PREP;
      PREP:    state_n = MAC;
      MAC:     if (k_tc) state_n = DRAIN;
      DRAIN:   state_n = OUT;
      OUT:     if (output_ready)
                 state_n = row_tc ? LOAD : PREP;
      default: state_n = LOAD;
    endcase
  end

  // output values for the upcoming state, registered below
  always_comb begin
    ir_d = 1'b0;
    ov_d = 1'b0;
    ca_d = 1'b0;
    ax_d = '0;
    aw_d = '0;
    kx   = (state == MAC) ? k_cnt + XW'(1) : '0;
    unique case (state_n)
      LOAD: begin
        ir_d = 1'b1;
        ax_d = accept ? load_cnt + XW'(1) : load_cnt;
      end
      PREP: ca_d = 1'b1;
      MAC: begin
        ax_d = kx;
        aw_d = WW'(row_cnt) * WW'(N) + WW'(kx);
      end
      OUT:  ov_d = 1'b1;
      default: ;
    endcase
  end

  // output registers; en_acc trails MAC issue by the read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
      clear_acc    <= 1'b0;
      en_acc       <= 1'b0;
      addr_x       <= '0;
      addr_w       <= '0;
    end else begin
      input_ready  <= ir_d;
      output_valid <= ov_d;
      clear_acc    <= ca_d;
      en_acc       <= (state == MAC);
      addr_x       <= ax_d;
      addr_w       <= aw_d;
    end
  end

`ifdef FC_STALL_CNT_EN
  // saturating count of stalled OUT cycles, cleared on LOAD entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (state_n == LOAD && state != LOAD)
      stall_cnt <= '0;
    else if (state == OUT && !output_ready &&
             stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl (M=16, N=8).
// Checks stall_cnt when FC_STALL_CNT_EN is defined.
module tb_fc_seq_ctrl;

  localparam int M = 16;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       input_valid = 1'b0;
  logic       output_ready = 1'b0;
  logic       input_ready;
  logic       output_valid;
  logic [2:0] addr_x;
  logic       wr_en_x;
  logic [6:0] addr_w;
  logic       wr_en_w;
  logic       clear_acc;
  logic       en_acc;
  logic [0:0] f_sel;
`ifdef FC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs = 0;
  int p0 = 0;
  int p1 = 0;
  int pt = 0;

  fc_seq_ctrl #(.M(M), .N(N), .T(8), .P(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .addr_x       (addr_x),
    .wr_en_x      (wr_en_x),
    .addr_w       (addr_w),
    .wr_en_w      (wr_en_w),
    .clear_acc    (clear_acc),
    .en_acc       (en_acc),
    .f_sel        (f_sel)
`ifdef FC_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ir"}, input_ready, 0);
    chk({tag, ".ov"}, output_valid, 0);
    chk({tag, ".wx"}, wr_en_x, 0);
    chk({tag, ".clr"}, clear_acc, 0);
    chk({tag, ".en"}, en_acc, 0);
    chk({tag, ".ax"}, addr_x, 0);
    chk({tag, ".aw"}, addr_w, 0);
    chk({tag, ".ww"}, wr_en_w, 0);
    chk({tag, ".fs"}, f_sel, 0);
  endtask

  task automatic run_row(input int r, input int stall,
                         output int prep_cyc);
    int en_cnt;
    int ov_len;
    en_cnt = 0;
    ov_len = 0;
    prep_cyc = cyc;
    chk("prep_clr", clear_acc, 1);
    chk("prep_en", en_acc, 0);
    chk("prep_ov", output_valid, 0);
    chk("prep_ir", input_ready, 0);
    step;
    for (int k = 0; k < N; k++) begin
      chk("mac_ax", addr_x, k);
      chk("mac_aw", addr_w, (r * N + k) % (M * N));
      chk("mac_clr", clear_acc, 0);
      chk("mac_ir", input_ready, 0);
      chk("mac_wx", wr_en_x, 0);
      chk("mac_en", en_acc, (k != 0) ? 1 : 0);
      if (en_acc) en_cnt++;
      step;
    end
    chk("drain_en", en_acc, 1);
    chk("drain_ov", output_valid, 0);
    if (en_acc) en_cnt++;
    if (stall > 0) output_ready = 1'b0;
    step;
    for (int j = 0; j < stall; j++) begin
      chk("stall_ov", output_valid, 1);
      chk("stall_en", en_acc, 0);
      chk("stall_clr", clear_acc, 0);
      if (output_valid) ov_len++;
      step;
    end
    output_ready = 1'b1;
    chk("out_ov", output_valid, 1);
    chk("out_en", en_acc, 0);
    chk("out_clr", clear_acc, 0);
    if (output_valid) begin
      ov_len++;
      hs++;
    end
`ifdef FC_STALL_CNT_EN
    if (stall > 0) chk("stall_cnt", stall_cnt, stall);
`endif
    chk("en_acc_cnt", en_cnt, N);
    chk("ov_len", ov_len, stall + 1);
    step;
  endtask

  initial begin
    reset = 1'b0;
    input_valid = 1'b1;
    output_ready = 1'b1;
    repeat (3) step;
    chk_zero("rst");
`ifdef FC_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif

    reset = 1'b1;
    #1;
    chk("ir_pre_edge", input_ready, 0);
    chk("wx_pre_edge", wr_en_x, 0);
    step;

    for (int i = 0; i < N; i++) begin
      chk("ld_ir", input_ready, 1);
      chk("ld_wx", wr_en_x, 1);
      chk("ld_ax", addr_x, i);
      chk("ld_clr", clear_acc, 0);
      step;
    end
    chk("post_ld_ir", input_ready, 0);
    chk("post_ld_wx", wr_en_x, 0);

    for (int r = 0; r < M; r++) begin
      run_row(r, (r == 3) ? 5 : 0, pt);
      if (r == 0) p0 = pt;
      if (r == 1) p1 = pt;
    end
    chk("row_period", p1 - p0, N + 3);
    chk("hs_count", hs, M);
    chk("back_ir", input_ready, 1);
    chk("back_ov", output_valid, 0);
    chk("back_ax", addr_x, 0);
    chk("back_wx", wr_en_x, 1);
`ifdef FC_STALL_CNT_EN
    chk("back_stall", stall_cnt, 0);
`endif

    for (int i = 0; i < 3; i++) begin
      chk("ld2_ax", addr_x, i);
      chk("ld2_wx", wr_en_x, 1);
      step;
    end
    input_valid = 1'b0;
    #1;
    chk("gap_wx", wr_en_x, 0);
    chk("gap_ax", addr_x, 3);
    step;
    chk("gap_hold_ax", addr_x, 3);
    chk("gap_ir", input_ready, 1);
    input_valid = 1'b1;
    #1;
    for (int i = 3; i < N; i++) begin
      chk("ld2_ax", addr_x, i);
      chk("ld2_wx", wr_en_x, 1);
      step;
    end

    for (int r = 0; r < 7; r++)
      run_row(r, 0, pt);

    chk("r7_clr", clear_acc, 1);
    step;
    repeat (4) step;
    chk("r7k4_ax", addr_x, 4);
    chk("r7k4_aw", addr_w, 7 * N + 4);
    chk("r7k4_en", en_acc, 1);

    reset = 1'b0;
    #1;
    chk_zero("rst_mac");
`ifdef FC_STALL_CNT_EN
    chk("rst_mac_stall", stall_cnt, 0);
`endif
    step;
    step;
    chk_zero("rst_hold");
    reset = 1'b1;
    step;
    chk("rel_ir", input_ready, 1);
    chk("rel_ax", addr_x, 0);
    chk("rel_wx", wr_en_x, 1);
    step;
    chk("rel_ax1", addr_x, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
